// File: rtl/bit_scan_scheduler_pkg.sv
// bit_scan_scheduler_pkg
//    Shared definitions for the bit-scan scheduler: vector width, index/count
//    width and the scheduler FSM state encoding.
package bit_scan_scheduler_pkg;

   localparam int WIDTH = 128;
   localparam int IDX_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bit_scan_scheduler_detect.sv
// DETECT_LOWEST_HIGH
//    Combinational lowest-set-bit detector.
//    Ports:
//       d_i   [WIDTH-1:0]  vector to search
//       idx_o [IDX_W-1:0]  index of the lowest set bit of d_i (0 when d_i==0)
module DETECT_LOWEST_HIGH
   import bit_scan_scheduler_pkg::*;
#(
   parameter int W  = WIDTH,
   parameter int IW = IDX_W
) (
   input  logic [W-1:0]  d_i,
   output logic [IW-1:0] idx_o
);

   // Walk from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx_o = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (d_i[i]) begin
            idx_o = IW'(i);
         end
      end
   end

endmodule

// File: rtl/bit_scan_scheduler.sv
// bit_scan_scheduler
//    Accepts a request vector and hands out the indices of its set bits,
//    lowest first, one per accepted output cycle. Reports completion with a
//    one-cycle Done pulse carrying the number of indices handed off.
//    Ports:
//       CLK, RST              clock, synchronous active-high reset
//       Din, Din_valid/ready  vector input handshake (ready only in IDLE)
//       Dout, Dout_valid/ready index output handshake, Last marks final index
//       Flush                 abort an ongoing scan
//       Done, Empty, Count    end-of-scan pulse, zero-vector flag, index count
module bit_scan_scheduler
   import bit_scan_scheduler_pkg::*;
(
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] Din,
   input  logic             Din_valid,
   output logic             Din_ready,
   output logic [IDX_W-1:0] Dout,
   output logic             Dout_valid,
   input  logic             Dout_ready,
   output logic             Last,
   input  logic             Flush,
   output logic             Done,
   output logic             Empty,
   output logic [IDX_W-1:0] Count
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [IDX_W-1:0] count_q, count_d;
   logic             empty_q, empty_d;

   logic [WIDTH-1:0] pending_clr;
   logic             last_bit;

   DETECT_LOWEST_HIGH #(
      .W  (WIDTH),
      .IW (IDX_W)
   ) u_detect (
      .d_i   (pending_q),
      .idx_o (Dout)
   );

   // x & (x-1) drops the lowest set bit; a zero result means at most one bit
   // was set, so the nonzero check keeps Last low on an empty register.
   assign pending_clr = pending_q & (pending_q - WIDTH'(1));
   assign last_bit    = (pending_q != '0) && (pending_clr == '0);

   assign Din_ready  = (state_q == IDLE);
   assign Dout_valid = (state_q == SCAN);
   assign Done       = (state_q == DONE);
   assign Empty      = empty_q & (state_q == DONE);
   assign Last       = last_bit;
   assign Count      = count_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         pending_q <= '0;
         count_q   <= '0;
         empty_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         empty_q   <= empty_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      count_d   = count_q;
      empty_d   = empty_q;
      unique case (state_q)
         IDLE: begin
            if (Din_valid) begin
               pending_d = Din;
               count_d   = '0;
               if (Din != '0) begin
                  state_d = SCAN;
                  empty_d = 1'b0;
               end else begin
                  state_d = DONE;
                  empty_d = 1'b1;
               end
            end
         end
         SCAN: begin
            // Flush beats a same-cycle handshake: that index is not counted.
            if (Flush) begin
               pending_d = '0;
               empty_d   = 1'b0;
               state_d   = DONE;
            end else if (Dout_ready) begin
               pending_d = pending_clr;
               count_d   = count_q + IDX_W'(1);
               if (last_bit) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: doc/bit_scan_scheduler.md
BIT_SCAN_SCHEDULER -- requirements
Module: bit_scan_scheduler

Interface
REQ-001 Parameter: WIDTH, 128, bit-vector width; only 128 is supported.
REQ-002 Parameter: IDX_W, 8, index and count width; must hold values 0..WIDTH.
REQ-003 Port: CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 Port: RST  input  1  reset; synchronous and active-high.
REQ-005 Port: Din  input  WIDTH  request vector to scan.
REQ-006 Port: Din_valid  input  1  Din is valid.
REQ-007 Port: Din_ready  output  1  block accepts a new vector.
REQ-008 Port: Dout  output  IDX_W  index of the lowest pending set bit.
REQ-009 Port: Dout_valid  output  1  Dout is valid.
REQ-010 Port: Dout_ready  input  1  consumer accepts Dout.
REQ-011 Port: Last  output  1  qualifies Dout: this is the final pending index.
REQ-012 Port: Flush  input  1  abort the current scan.
REQ-013 Port: Done  output  1  one-cycle pulse at the end of every scan.
REQ-014 Port: Empty  output  1  qualifies Done: the loaded vector was zero.
REQ-015 Port: Count  output  IDX_W  number of indices handed off; valid while Done=1.

Function
REQ-016 FSM states SHALL be IDLE, SCAN and DONE.
REQ-017 Din_ready SHALL equal (state==IDLE); Din_valid outside IDLE SHALL be ignored.
REQ-018 On a Din handshake in IDLE, the block SHALL:
- load the pending register with Din;
- clear Count to 0;
- go to SCAN if Din!=0, or to DONE with Empty=1 if Din==0.
REQ-019 Dout_valid SHALL equal (state==SCAN); first Dout_valid SHALL occur the cycle after the Din handshake.
REQ-020 Dout SHALL be the index of the lowest set bit of pending; Last SHALL be 1 when pending has exactly one set bit.
REQ-021 While Dout_valid=1 and Dout_ready=0, Dout and Last SHALL hold stable.
REQ-022 On a Dout handshake, the block SHALL:
- clear the lowest set bit of pending;
- increment Count;
- go to DONE if Last=1, else stay in SCAN.
REQ-023 Throughput SHALL be one index per cycle while Dout_ready=1; k set bits take 1 accept cycle + k SCAN cycles + 1 DONE cycle.
REQ-024 Flush in SCAN SHALL discard pending and go to DONE with Empty=0; Count SHALL hold its value.
REQ-025 Flush SHALL win over a simultaneous Dout handshake: that index is not counted, and the consumer must treat it as dropped.
REQ-026 Flush in IDLE or DONE SHALL have no effect.
REQ-027 In DONE, Done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-028 Count SHALL never exceed WIDTH; no wrap-around occurs (WIDTH=128 fits IDX_W=8).

Reset
REQ-029 RST=1 at a posedge SHALL force, on the next cycle and from any state including mid-SCAN:
- state=IDLE, pending=0, Count=0;
- Dout_valid=0, Done=0, Empty=0, Dout=0, Last=0;
- Din_ready=1.
REQ-030 RST SHALL take priority over every handshake and over Flush in the same cycle.

Structure
REQ-031 A shared package SHALL hold WIDTH, IDX_W and the FSM state encoding.
REQ-032 One sub-module SHALL exist: the team's existing combinational lowest-set-bit detector DETECT_LOWEST_HIGH (128-bit in, 8-bit index out), instantiated on the pending register.
REQ-033 Last SHALL be computed in-block from pending & (pending-1)==0.

Verification
REQ-034 Din=2, Dout_ready=1 -> Dout=1 with Last=1; next cycle Done=1, Count=1, Empty=0.
REQ-035 Din=4444, Dout_ready=1 -> Dout=2,3,4,6,8,12 on consecutive cycles, Last only with 12; then Done=1, Count=6.
REQ-036 Din=0 -> no Dout_valid; Done=1 and Empty=1 one cycle after accept, Count=0; Din_ready=1 the cycle after.
REQ-037 Din bits 0 and 127 set, Dout_ready held low 3 cycles -> Dout holds 0 for 4 cycles; then Dout=127 with Last=1; Count=2.
REQ-038 Din=0xFF: 3 handshakes, then Flush together with the 4th handshake -> Done=1, Count=3, Empty=0; Din_ready=1 the next cycle.
REQ-039 RST pulsed mid-SCAN of Din=0xF0 -> next cycle all outputs at reset values; a new Din=0x1 then yields Dout=0 with Last=1.
